pkt_sync_fifo: RTL and testbench

- Single-clock packet FIFO that buffers audio packets between the I2S packet producer and the DSP consumer.
- Packets are pushed on a one-cycle change strobe and popped under a read enable.
- Each popped packet is presented on a registered output with a one-cycle "new packet" strobe.
- Sits in the audio DSP path ahead of the effect pipeline.

---
 rtl/pkt_sync_fifo_pkg.sv | 9 +
 rtl/pkt_fifo_mem.sv | 39 +++
 rtl/pkt_sync_fifo.sv | 79 +++++++
 tb/tb_pkt_sync_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_sync_fifo_pkg.sv
// Shared audio packet definitions for the I2S producer, the FIFO and the DSP consumer.
package pkt_sync_fifo_pkg;

  localparam int PKT_WIDTH_DEFAULT = 16;
  localparam int DEPTH_DEFAULT     = 16;

  typedef logic [PKT_WIDTH_DEFAULT-1:0] pkt_t;

endpackage

// File: rtl/pkt_fifo_mem.sv
// DEPTH x PKT_WIDTH packet store: synchronous write port, registered read-before-write read port.
module pkt_fifo_mem
  import pkt_sync_fifo_pkg::*;
#(
  parameter int PKT_WIDTH = PKT_WIDTH_DEFAULT,
  parameter int DEPTH     = DEPTH_DEFAULT,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wrEn,
  input  logic [AW-1:0]        wrAddr,
  input  logic [PKT_WIDTH-1:0] wrData,
  input  logic                 rdEn,
  input  logic [AW-1:0]        rdAddr,
  output logic [PKT_WIDTH-1:0] rdData
);

  logic [PKT_WIDTH-1:0] memArray [DEPTH];
  logic [PKT_WIDTH-1:0] rdReg = '0;

  always_ff @(posedge clk_i) begin
    if (wrEn) begin
      memArray[wrAddr] <= wrData;
    end
  end

  // When full, a pop and a push hit the same slot; the read must return the old head.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rdReg <= '0;
    end else if (rdEn) begin
      rdReg <= memArray[rdAddr];
    end
  end

  assign rdData = rdReg;

endmodule

// File: rtl/pkt_sync_fifo.sv
// Single-clock packet FIFO between the I2S packet producer and the DSP effect pipeline.
module pkt_sync_fifo
  import pkt_sync_fifo_pkg::*;
#(
  parameter int PKT_WIDTH = PKT_WIDTH_DEFAULT,
  parameter int DEPTH     = DEPTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [PKT_WIDTH-1:0] pkt_i,
  input  logic                 pktChanged_i,
  input  logic                 rdEN_i,
  output logic [PKT_WIDTH-1:0] pktOut_s_o,
  output logic                 pktOutChanged_c_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wrPtr      = '0;
  logic [AW-1:0] rdPtr      = '0;
  logic [AW:0]   count      = '0;
  logic          outChanged = 1'b0;

  logic doPush;
  logic doPop;
  logic isFull;
  logic isEmpty;

  assign isFull  = (count == COUNT_FULL);
  assign isEmpty = (count == '0);

  // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
  assign doPop  = rdEN_i && !isEmpty;
  assign doPush = pktChanged_i && (!isFull || doPop);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      outChanged <= 1'b0;
    end else begin
      outChanged <= doPop;
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  pkt_fifo_mem #(
    .PKT_WIDTH (PKT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wrEn    (doPush),
    .wrAddr  (wrPtr),
    .wrData  (pkt_i),
    .rdEn    (doPop),
    .rdAddr  (rdPtr),
    .rdData  (pktOut_s_o)
  );

  assign pktOutChanged_c_o = outChanged;
  assign full_o            = isFull;
  assign empty_o           = isEmpty;

endmodule

// File: tb/tb_pkt_sync_fifo.sv
// Directed bench for pkt_sync_fifo: reset, latency, ordering, overflow, full push/pop and mid-stream reset.
module tb_pkt_sync_fifo;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [15:0] pkt_i = '0;
  logic        pktChanged_i = 1'b0;
  logic        rdEN_i = 1'b0;
  logic [15:0] pktOut_s_o;
  logic        pktOutChanged_c_o;
  logic        full_o;
  logic        empty_o;

  int nChecks = 0;
  int nFails  = 0;

  logic [15:0] seen [$];

  pkt_sync_fifo #(.PKT_WIDTH(16), .DEPTH(16)) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .pkt_i             (pkt_i),
    .pktChanged_i      (pktChanged_i),
    .rdEN_i            (rdEN_i),
    .pktOut_s_o        (pktOut_s_o),
    .pktOutChanged_c_o (pktOutChanged_c_o),
    .full_o            (full_o),
    .empty_o           (empty_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle so outputs reflect that edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; pktChanged_i = 1'b0; rdEN_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    nChecks++;
    if (pktOut_s_o !== 16'h0000) begin nFails++; $display("FAIL reset_pktOut got=%h exp=0000", pktOut_s_o); end
    nChecks++;
    if (pktOutChanged_c_o !== 1'b0) begin nFails++; $display("FAIL reset_changed got=%b exp=0", pktOutChanged_c_o); end
    nChecks++;
    if (empty_o !== 1'b1) begin nFails++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    nChecks++;
    if (full_o !== 1'b0) begin nFails++; $display("FAIL reset_full got=%b exp=0", full_o); end
    rst_n_i = 1'b1;
  endtask

  task automatic test_writes_after_reset();
    logic [15:0] vals [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    seen.delete();
    rdEN_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pktChanged_i = (i % 2 == 0) && (i < 8);
      pkt_i = (i < 8) ? vals[i/2] : 16'h0;
      tick();
      if (pktOutChanged_c_o) seen.push_back(pktOut_s_o);
    end
    pktChanged_i = 1'b0;
    nChecks++;
    if (seen.size() != 4) begin nFails++; $display("FAIL after_reset_pulses got=%0d exp=4", seen.size()); end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      nChecks++;
      if (seen[i] !== vals[i]) begin nFails++; $display("FAIL after_reset_val%0d got=%h exp=%h", i, seen[i], vals[i]); end
    end
    nChecks++;
    if (empty_o !== 1'b1) begin nFails++; $display("FAIL after_reset_empty got=%b exp=1", empty_o); end
    rdEN_i = 1'b0;
  endtask

  task automatic test_single_push();
    int pulses = 0;
    int firstIdx = -1;
    rdEN_i = 1'b1;
    pkt_i = 16'h0001; pktChanged_i = 1'b1;
    tick();
    pktChanged_i = 1'b0; pkt_i = 16'h5555;
    nChecks++;
    if (pktOutChanged_c_o !== 1'b0) begin nFails++; $display("FAIL single_no_bypass got=%b exp=0", pktOutChanged_c_o); end
    for (int i = 0; i < 55; i++) begin
      tick();
      if (pktOutChanged_c_o) begin
        pulses++;
        if (firstIdx < 0) firstIdx = i;
      end
    end
    nChecks++;
    if (pulses != 1) begin nFails++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
    nChecks++;
    if (firstIdx != 0) begin nFails++; $display("FAIL single_latency got=%0d exp=0", firstIdx); end
    nChecks++;
    if (pktOut_s_o !== 16'h0001) begin nFails++; $display("FAIL single_hold got=%h exp=0001", pktOut_s_o); end
    rdEN_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [6] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF};
    int idx [$];
    seen.delete();
    rdEN_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pktChanged_i = (i < 6);
      pkt_i = (i < 6) ? vals[i] : 16'h0;
      tick();
      if (pktOutChanged_c_o) begin seen.push_back(pktOut_s_o); idx.push_back(i); end
    end
    pktChanged_i = 1'b0;
    nChecks++;
    if (seen.size() != 6) begin nFails++; $display("FAIL b2b_pulses got=%0d exp=6", seen.size()); end
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      nChecks++;
      if (seen[i] !== vals[i] || idx[i] != i + 1) begin
        nFails++; $display("FAIL b2b_val%0d got=%h@%0d exp=%h@%0d", i, seen[i], idx[i], vals[i], i + 1);
      end
    end
    rdEN_i = 1'b0;
  endtask

  task automatic test_overflow();
    rdEN_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      pkt_i = 16'(i); pktChanged_i = 1'b1;
      tick();
      if (i == 14) begin
        nChecks++;
        if (full_o !== 1'b0) begin nFails++; $display("FAIL ovf_full15 got=%b exp=0", full_o); end
      end
      if (i == 15) begin
        nChecks++;
        if (full_o !== 1'b1) begin nFails++; $display("FAIL ovf_full16 got=%b exp=1", full_o); end
      end
    end
    pktChanged_i = 1'b0;
    nChecks++;
    if (full_o !== 1'b1 || pktOutChanged_c_o !== 1'b0) begin
      nFails++; $display("FAIL ovf_after17 full=%b chg=%b exp full=1 chg=0", full_o, pktOutChanged_c_o);
    end
    seen.delete();
    rdEN_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pktOutChanged_c_o) seen.push_back(pktOut_s_o);
    end
    rdEN_i = 1'b0;
    nChecks++;
    if (seen.size() != 16) begin nFails++; $display("FAIL ovf_pops got=%0d exp=16", seen.size()); end
    for (int i = 0; i < 16 && i < seen.size(); i++) begin
      nChecks++;
      if (seen[i] !== 16'(i)) begin nFails++; $display("FAIL ovf_val%0d got=%h exp=%h", i, seen[i], 16'(i)); end
    end
    nChecks++;
    if (empty_o !== 1'b1 || full_o !== 1'b0) begin
      nFails++; $display("FAIL ovf_drained empty=%b full=%b exp empty=1 full=0", empty_o, full_o);
    end
  endtask

  task automatic test_full_push_pop_and_reset();
    logic [15:0] exp [$];
    rdEN_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pkt_i = 16'h0100 + 16'(i); pktChanged_i = 1'b1;
      tick();
    end
    seen.delete();
    rdEN_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pkt_i = 16'h0200 + 16'(i); pktChanged_i = 1'b1;
      tick();
      if (pktOutChanged_c_o) seen.push_back(pktOut_s_o);
      nChecks++;
      if (full_o !== 1'b1) begin nFails++; $display("FAIL fullpp_full%0d got=%b exp=1", i, full_o); end
    end
    pktChanged_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pktOutChanged_c_o) seen.push_back(pktOut_s_o);
    end
    rdEN_i = 1'b0;
    for (int i = 4; i < 16; i++) exp.push_back(16'h0100 + 16'(i));
    for (int i = 0; i < 4; i++) exp.push_front(16'h0103 - 16'(i));
    for (int i = 0; i < 4; i++) exp.push_back(16'h0200 + 16'(i));
    nChecks++;
    if (seen.size() != 20) begin nFails++; $display("FAIL fullpp_pops got=%0d exp=20", seen.size()); end
    for (int i = 0; i < 20 && i < seen.size(); i++) begin
      nChecks++;
      if (seen[i] !== exp[i]) begin nFails++; $display("FAIL fullpp_val%0d got=%h exp=%h", i, seen[i], exp[i]); end
    end

    for (int i = 0; i < 5; i++) begin
      pkt_i = 16'h0300 + 16'(i); pktChanged_i = 1'b1;
      tick();
    end
    pktChanged_i = 1'b0;
    nChecks++;
    if (empty_o !== 1'b0) begin nFails++; $display("FAIL midrst_queued empty=%b exp=0", empty_o); end
    rst_n_i = 1'b0;
    tick(); tick();
    rst_n_i = 1'b1;
    nChecks++;
    if (empty_o !== 1'b1 || pktOut_s_o !== 16'h0000) begin
      nFails++; $display("FAIL midrst_state empty=%b out=%h exp empty=1 out=0000", empty_o, pktOut_s_o);
    end
    seen.delete();
    rdEN_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pktOutChanged_c_o) seen.push_back(pktOut_s_o);
    end
    rdEN_i = 1'b0;
    nChecks++;
    if (seen.size() != 0) begin nFails++; $display("FAIL midrst_pulses got=%0d exp=0", seen.size()); end
  endtask

  initial begin
    test_reset();
    test_writes_after_reset();
    test_single_push();
    test_back_to_back();
    test_overflow();
    test_full_push_pop_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
